// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 16-bit CPU.
// Holds the PC, freezes on stall, squashes on redirect and parks after a HALT opcode.
module fetch_stage #(
  parameter int          ADDR_W    = 16,
  parameter int          INSTR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC  = 16'h0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0000,
  parameter logic [3:0]  HALT_OP   = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc_plus1,
  output logic               ifid_valid,
  output logic               halted
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   pc_p0, pc_next;
  logic [INSTR_W-1:0]  instr_p1, instr_next;
  logic [ADDR_W-1:0]   pc_plus1_p1, pc_plus1_next;
  logic                vld_p1, vld_next;
  logic                halted_next;
  logic                is_halt;

  function automatic logic [ADDR_W-1:0] incr_wrap(input logic [ADDR_W-1:0] a);
    return a + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

  assign imem_addr     = pc_p0;
  assign ifid_instr    = instr_p1;
  assign ifid_pc_plus1 = pc_plus1_p1;
  assign ifid_valid    = vld_p1;
  assign is_halt       = (imem_data[INSTR_W-1 -: 4] == HALT_OP);

  always_comb begin
    state_next    = state;
    pc_next       = pc_p0;
    instr_next    = instr_p1;
    pc_plus1_next = pc_plus1_p1;
    vld_next      = vld_p1;
    halted_next   = halted;
    if (redirect) begin
      pc_next       = redirect_pc;
      instr_next    = NOP_INSTR;
      pc_plus1_next = '0;
      vld_next      = 1'b0;
      state_next    = RUN;
      halted_next   = 1'b0;
    end else if (!stall) begin
      case (state)
        RUN: begin
          instr_next    = imem_data;
          pc_plus1_next = incr_wrap(pc_p0);
          vld_next      = 1'b1;
          if (is_halt) begin
            state_next  = HALTED;
            halted_next = 1'b1;
          end else begin
            pc_next = incr_wrap(pc_p0);
          end
        end
        HALTED: begin
          // Parked: keep emitting bubbles until a redirect or reset.
          instr_next = NOP_INSTR;
          vld_next   = 1'b0;
        end
        default: state_next = RUN;
      endcase
    end
  end

  // Stage boundary: PC (p0) and IF/ID register (p1)
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      halted      <= 1'b0;
      pc_p0       <= RESET_PC;
      instr_p1    <= NOP_INSTR;
      pc_plus1_p1 <= '0;
      vld_p1      <= 1'b0;
    end else begin
      state       <= state_next;
      halted      <= halted_next;
      pc_p0       <= pc_next;
      instr_p1    <= instr_next;
      pc_plus1_p1 <= pc_plus1_next;
      vld_p1      <= vld_next;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: straight-line fetch, stall, redirect, wrap, halt, reset.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus1;
  logic        ifid_valid;
  logic        halted;

  logic [15:0] mem [0:65535];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_data(imem_data),
    .ifid_instr(ifid_instr), .ifid_pc_plus1(ifid_pc_plus1),
    .ifid_valid(ifid_valid), .halted(halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [15:0] instr,
                            input logic [15:0] pp1, input logic vld);
    check({tag, ".instr"}, {16'h0, ifid_instr}, {16'h0, instr});
    check({tag, ".pp1"}, {16'h0, ifid_pc_plus1}, {16'h0, pp1});
    check({tag, ".valid"}, {31'h0, ifid_valid}, {31'h0, vld});
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[0]      = 16'h1123;
    mem[1]      = 16'h2245;
    mem[2]      = 16'h3367;
    mem[3]      = 16'h4489;
    mem[4]      = 16'h6001;
    mem[5]      = 16'hF000;
    mem[16'h10] = 16'h8010;
    mem[16'h40] = 16'h5A5A;
    mem[16'hFFFF] = 16'h7777;

    // Reset for two cycles
    step();
    step();
    check("rst.valid", {31'h0, ifid_valid}, 32'd0);
    check("rst.addr", {16'h0, imem_addr}, 32'h0);
    check("rst.halted", {31'h0, halted}, 32'd0);
    rst = 1'b0;

    // Straight-line fetch
    step(); check_ifid("seq0", 16'h1123, 16'd1, 1'b1);
    step(); check_ifid("seq1", 16'h2245, 16'd2, 1'b1);
    check("seq1.addr", {16'h0, imem_addr}, 32'd2);

    // Stall hold for two cycles
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      check_ifid("stall", 16'h2245, 16'd2, 1'b1);
      check("stall.addr", {16'h0, imem_addr}, 32'd2);
    end
    stall = 1'b0;
    step(); check_ifid("unstall", 16'h3367, 16'd3, 1'b1);
    step(); check_ifid("seq3", 16'h4489, 16'd4, 1'b1);
    step(); check_ifid("seq4", 16'h6001, 16'd5, 1'b1);
    check("seq4.addr", {16'h0, imem_addr}, 32'd5);

    // Halt at address 5
    step(); check_ifid("halt", 16'hF000, 16'd6, 1'b1);
    check("halt.halted", {31'h0, halted}, 32'd1);
    check("halt.addr", {16'h0, imem_addr}, 32'd5);
    for (int k = 0; k < 3; k++) begin
      step();
      check("halted.instr", {16'h0, ifid_instr}, 32'h0);
      check("halted.valid", {31'h0, ifid_valid}, 32'd0);
      check("halted.addr", {16'h0, imem_addr}, 32'd5);
    end

    // Redirect out of HALTED
    redirect = 1'b1; redirect_pc = 16'h0010;
    step();
    redirect = 1'b0;
    check("hredir.halted", {31'h0, halted}, 32'd0);
    check_ifid("hredir", 16'h0000, 16'h0000, 1'b0);
    check("hredir.addr", {16'h0, imem_addr}, 32'h10);
    step(); check_ifid("resume", 16'h8010, 16'h0011, 1'b1);

    // Redirect beats stall
    redirect = 1'b1; redirect_pc = 16'h0040; stall = 1'b1;
    step();
    redirect = 1'b0; stall = 1'b0;
    check_ifid("rvs", 16'h0000, 16'h0000, 1'b0);
    check("rvs.addr", {16'h0, imem_addr}, 32'h40);
    step(); check_ifid("rvs.fetch", 16'h5A5A, 16'h0041, 1'b1);

    // PC wrap
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    step();
    redirect = 1'b0;
    step(); check_ifid("wrap", 16'h7777, 16'h0000, 1'b1);
    check("wrap.addr", {16'h0, imem_addr}, 32'h0);

    // Halt again, stall while HALTED, then reset with stall held
    redirect = 1'b1; redirect_pc = 16'h0005;
    step();
    redirect = 1'b0;
    step();
    check("halt2.halted", {31'h0, halted}, 32'd1);
    stall = 1'b1;
    step();
    check_ifid("hstall", 16'hF000, 16'd6, 1'b1);
    rst = 1'b1;
    step();
    check_ifid("mrst", 16'h0000, 16'h0000, 1'b0);
    check("mrst.halted", {31'h0, halted}, 32'd0);
    check("mrst.addr", {16'h0, imem_addr}, 32'h0);
    rst = 1'b0; stall = 1'b0;
    step(); check_ifid("postrst", 16'h1123, 16'd1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 16-bit pipelined CPU, sitting directly upstream of the hazard detector and the decode stage.
- Holds the PC, drives the instruction-memory address, and latches the fetched word into IF/ID.
- Freezes on the hazard detector's stall.
- Squashes and redirects on a resolved branch or jump.
- Stops fetching after a HALT opcode.

Parameters:
- ADDR_W, 16, PC / instruction-memory word-address width
- INSTR_W, 16, instruction width; opcode is bits [15:12]
- RESET_PC, 16'h0000, PC value loaded on reset
- NOP_INSTR, 16'h0000, bubble word inserted into IF/ID
- HALT_OP, 4'hF, opcode that stops fetching

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard-detector stall; hold PC and IF/ID this cycle
- redirect  in  1  branch/jump taken; flush IF/ID and load redirect_pc
- redirect_pc  in  ADDR_W  target word address for redirect
- imem_addr  out  ADDR_W  instruction-memory address; combinationally equal to pc
- imem_data  in  INSTR_W  instruction word at imem_addr, same cycle (asynchronous ROM)
- ifid_instr  out  INSTR_W  registered instruction to decode / hazard detector
- ifid_pc_plus1  out  ADDR_W  registered address of the fetched instruction + 1
- ifid_valid  out  1  1 = ifid_instr is a real fetched instruction, 0 = bubble
- halted  out  1  registered; 1 while in HALTED state

Behaviour:
- Reset, which has priority over everything:
  - pc <= RESET_PC; ifid_instr <= NOP_INSTR; ifid_pc_plus1 <= 0; ifid_valid <= 0; state <= RUN; halted <= 0.
  - Reset asserted mid-operation discards all pending state on that edge.
  - First fetch of RESET_PC occurs in the cycle after rst deasserts.
- Arithmetic:
  - pc+1 is computed modulo 2^ADDR_W, so 16'hFFFF wraps to 16'h0000.
  - No other PC arithmetic is done in this block; branch targets arrive precomputed.
- Priority on each edge: rst > redirect > stall > normal.
- State RUN:
  - redirect=1 (regardless of stall): pc <= redirect_pc; ifid_instr <= NOP_INSTR; ifid_valid <= 0; ifid_pc_plus1 <= 0; stay RUN.
  - else stall=1: pc, ifid_instr, ifid_pc_plus1 and ifid_valid all hold their values.
  - else, normal: ifid_instr <= imem_data; ifid_pc_plus1 <= pc+1; ifid_valid <= 1.
    - If imem_data[15:12] != HALT_OP: pc <= pc+1.
    - If imem_data[15:12] == HALT_OP: pc holds; state <= HALTED; halted <= 1.
- State HALTED:
  - redirect=1: pc <= redirect_pc; IF/ID flushed as in RUN; state <= RUN; halted <= 0. A branch older than HALT squashes it.
  - else stall=1: hold all of pc and IF/ID, so the HALT word stays in IF/ID until the stall releases.
  - else: pc holds; ifid_instr <= NOP_INSTR; ifid_valid <= 0. Bubbles then continue indefinitely.
  - Only rst or redirect leaves HALTED.
- Latency:
  - An instruction at address A appears on ifid_instr one edge after pc==A with no stall or redirect.
  - Redirect-to-first-valid-fetch latency is 2 edges: one to load pc, one to latch the word.
- imem_addr is always exactly pc, including during stall, reset and HALTED.
- Inputs stall and redirect are sampled only at the rising edge. No combinational path from stall/redirect to any output.

Test Plan:
- Reset and straight-line fetch:
  - Stimulus: rst for 2 cycles, memory[0..3] = 16'h1123, 16'h2245, 16'h3367, 16'h4489, no stall.
  - Required: during reset, ifid_valid=0 and imem_addr=0.
  - Required: on the successive edges after release, ifid_instr = 16'h1123, 16'h2245, 16'h3367, 16'h4489, with ifid_pc_plus1 = 1, 2, 3, 4 and ifid_valid=1.
- Stall hold:
  - Stimulus: stall=1 for 2 cycles while ifid_instr=16'h2245 and pc=2.
  - Required: ifid_instr stays 16'h2245, pc/imem_addr stays 2, ifid_valid stays 1.
  - Required: on release, next ifid_instr = memory[2].
- Redirect beats stall:
  - Stimulus: redirect=1, redirect_pc=16'h0040 and stall=1 on the same edge.
  - Required: ifid_instr=NOP_INSTR, ifid_valid=0, pc=16'h0040.
  - Required: next edge ifid_instr=memory[0x40], ifid_pc_plus1=16'h0041.
- PC wrap:
  - Stimulus: redirect to 16'hFFFF, then no stall.
  - Required: ifid_instr=memory[0xFFFF] with ifid_pc_plus1=16'h0000; next fetch address 16'h0000.
- Halt:
  - Stimulus: memory[5]=16'hF000, run from pc=5.
  - Required: ifid_instr=16'hF000 with ifid_valid=1, halted=1, pc stays 5.
  - Required: all later edges give ifid_instr=NOP_INSTR, ifid_valid=0.
  - Required: a redirect to 16'h0010 clears halted and resumes fetch at 16'h0010.
- Reset mid-operation:
  - Stimulus: assert rst while HALTED and stall=1.
  - Required: next edge pc=RESET_PC, halted=0, ifid_valid=0, ifid_instr=NOP_INSTR.
